io_bus_arbiter: RTL and testbench

//  Two-master arbiter for the single peripheral bus of the I/O bridge (switches, buttons, LEDs, display data).

---
 rtl/io_bus_arbiter_pkg.sv | 16 +
 rtl/io_bus_arbiter_if.sv | 46 ++++
 rtl/io_bus_arbiter_arb_rr_pick2.sv | 21 ++
 rtl/io_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the I/O bus arbiter: FSM states, master ids, default widths.
package io_bus_arb_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundle of both master ports plus the bridge-side bus of the I/O bus arbiter.
interface io_bus_arbiter_if #(
    parameter int unsigned AW = io_bus_arb_pkg::DEF_AW,
    parameter int unsigned DW = io_bus_arb_pkg::DEF_DW
);
    logic          m0_req;
    logic          m0_wen;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_wen;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] s_addr;
    logic          s_wen;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;

    // slave: the arbiter itself; master: the requesters and the bridge around it
    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        input  m1_req, m1_wen, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output s_addr, s_wen, s_wdata
    );

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        output m1_req, m1_wen, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  s_addr, s_wen, s_wdata
    );

endinterface

// File: rtl/io_bus_arbiter_arb_rr_pick2.sv
// Combinational two-way picker: round-robin on ties, or CPU-first when fixed_prio is set.
module arb_rr_pick2
    import io_bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = M_CPU;
        if (req == 2'b11)
            winner = fixed_prio ? M_CPU : ~last_gnt;
        else if (req[1])
            winner = M_DBG;
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the I/O bridge bus: one whole transaction per grant, fixed read latency.
// Define ARB_FIXED_PRIO_EN to make the CPU win every tie instead of round-robin.
module io_bus_arbiter
    import io_bus_arb_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    io_bus_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(RD_LAT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          owner;
    logic          last_gnt;
    logic [1:0]    req;
    logic          win_id;
    logic          win_vld;
    logic          fixed_prio;
    logic          grant;
    logic          last_access;

    logic [AW-1:0] s_addr_q;
    logic          s_wen_q;
    logic [DW-1:0] s_wdata_q;
    logic [DW-1:0] rdata_q [2];
    logic [1:0]    gnt_q;
    logic [1:0]    ack_q;

    assign req = {bus.m1_req, bus.m0_req};

`ifdef ARB_FIXED_PRIO_EN
    assign fixed_prio = 1'b1;
`else
    assign fixed_prio = 1'b0;
`endif

    arb_rr_pick2 u_pick (
        .req        (req),
        .last_gnt   (last_gnt),
        .fixed_prio (fixed_prio),
        .winner     (win_id),
        .valid      (win_vld)
    );

    always_comb begin
        state_nx    = state;
        grant       = 1'b0;
        last_access = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    grant    = 1'b1;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == CW'(1)) begin
                    last_access = 1'b1;
                    state_nx    = ST_RESP;
                end
            end
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // s_wen is cleared every edge so the write strobe lasts only the first ACCESS cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            owner     <= M_CPU;
            last_gnt  <= M_DBG;
            s_addr_q  <= '0;
            s_wen_q   <= 1'b0;
            s_wdata_q <= '0;
            rdata_q   <= '{default: '0};
            gnt_q     <= '0;
            ack_q     <= '0;
        end else begin
            s_wen_q <= 1'b0;
            ack_q   <= '0;
            if (grant) begin
                owner    <= win_id;
                last_gnt <= win_id;
                cnt      <= CW'(RD_LAT);
                gnt_q    <= 2'b01 << win_id;
                if (win_id == M_DBG) begin
                    s_addr_q  <= bus.m1_addr;
                    s_wen_q   <= bus.m1_wen;
                    s_wdata_q <= bus.m1_wdata;
                end else begin
                    s_addr_q  <= bus.m0_addr;
                    s_wen_q   <= bus.m0_wen;
                    s_wdata_q <= bus.m0_wdata;
                end
            end else if (state == ST_ACCESS) begin
                cnt <= cnt - CW'(1);
                if (last_access) begin
                    rdata_q[owner] <= bus.s_rdata;
                    ack_q[owner]   <= 1'b1;
                end
            end else if (state == ST_RESP) begin
                gnt_q <= '0;
            end
        end
    end

    assign bus.s_addr   = s_addr_q;
    assign bus.s_wen    = s_wen_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.m0_gnt   = gnt_q[0];
    assign bus.m1_gnt   = gnt_q[1];
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_io_bus_arbiter;

    localparam int LAT  = 1;
    localparam int LAT3 = 3;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_bus_arbiter_if #(.AW(32), .DW(32)) bus ();
    io_bus_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    io_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    io_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // transaction-level model of the LAT=1 instance: mk counts cycles since the grant edge
    int          mk;
    logic        mown;
    logic        m_last;
    logic        mwen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] mrd [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mk     = 0;
        mown   = 1'b0;
        m_last = 1'b1;
        mwen   = 1'b0;
        maddr  = '0;
        mwdata = '0;
        mrd[0] = '0;
        mrd[1] = '0;
    endtask

    function automatic bit exp_ack(input logic m);
        return (mk == LAT + 1) && (mown == m);
    endfunction

    task automatic tick();
        logic [1:0]  r;
        logic [31:0] srd;
        r   = {bus.m1_req, bus.m0_req};
        srd = bus.s_rdata;
        if (mk == 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) mown = FIXED ? 1'b0 : ~m_last;
                else            mown = r[1];
                m_last = mown;
                mk     = 1;
                if (mown) begin
                    mwen = bus.m1_wen; maddr = bus.m1_addr; mwdata = bus.m1_wdata;
                end else begin
                    mwen = bus.m0_wen; maddr = bus.m0_addr; mwdata = bus.m0_wdata;
                end
            end
        end else if (mk <= LAT) begin
            if (mk == LAT) mrd[mown] = srd;
            mk++;
        end else begin
            mk = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("m0_gnt",   64'(bus.m0_gnt),   64'(mk != 0 && mown == 1'b0));
        chk("m1_gnt",   64'(bus.m1_gnt),   64'(mk != 0 && mown == 1'b1));
        chk("m0_ack",   64'(bus.m0_ack),   64'(exp_ack(1'b0)));
        chk("m1_ack",   64'(bus.m1_ack),   64'(exp_ack(1'b1)));
        chk("s_wen",    64'(bus.s_wen),    64'(mk == 1 && mwen));
        chk("s_addr",   64'(bus.s_addr),   64'(maddr));
        chk("s_wdata",  64'(bus.s_wdata),  64'(mwdata));
        chk("m0_rdata", 64'(bus.m0_rdata), 64'(mrd[0]));
        chk("m1_rdata", 64'(bus.m1_rdata), 64'(mrd[1]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int wens;
        int ack_cyc [$];
        int ack_who [$];

        {bus.m0_req, bus.m0_wen, bus.m0_addr, bus.m0_wdata} = '0;
        {bus.m1_req, bus.m1_wen, bus.m1_addr, bus.m1_wdata} = '0;
        bus.s_rdata = '0;
        {bus3.m0_req, bus3.m0_wen, bus3.m0_addr, bus3.m0_wdata} = '0;
        {bus3.m1_req, bus3.m1_wen, bus3.m1_addr, bus3.m1_wdata} = '0;
        bus3.s_rdata = '0;
        model_reset();

        // power-on reset
        @(posedge clk); @(posedge clk); #1;
        chk("rst_s_wen",  64'(bus.s_wen), 64'(0));
        chk("rst_gnt",    64'({bus.m1_gnt, bus.m0_gnt}), 64'(0));
        rst = 1'b0;
        tick(); tick();

        // reset asserted mid-ACCESS of a write
        bus.m0_req = 1'b1; bus.m0_wen = 1'b1; bus.m0_addr = 32'hFFFF_F060; bus.m0_wdata = 32'h55;
        tick();
        chk("t1_wen_before", 64'(bus.s_wen), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("t1_wen_async", 64'(bus.s_wen), 64'(0));
        chk("t1_gnt_async", 64'({bus.m1_gnt, bus.m0_gnt}), 64'(0));
        chk("t1_ack_async", 64'({bus.m1_ack, bus.m0_ack}), 64'(0));
        bus.m0_req = 1'b0; bus.m0_wen = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick(); tick(); tick();

        // RD_LAT=3 instance: m1 read, address held 3 cycles, data from the third
        bus3.m1_req = 1'b1; bus3.m1_wen = 1'b0; bus3.m1_addr = 32'hFFFF_F040;
        tick();
        for (int k = 1; k <= LAT3; k++) begin
            chk("t6_s_addr", 64'(bus3.s_addr), 64'(32'hFFFF_F040));
            chk("t6_gnt",    64'(bus3.m1_gnt), 64'(1));
            chk("t6_ack",    64'(bus3.m1_ack), 64'(0));
            chk("t6_s_wen",  64'(bus3.s_wen),  64'(0));
            bus3.s_rdata = 32'hC0DE_0000 + 32'(k);
            tick();
        end
        chk("t6_ack_n4", 64'(bus3.m1_ack),   64'(1));
        chk("t6_rdata",  64'(bus3.m1_rdata), 64'(32'hC0DE_0003));
        bus3.m1_req = 1'b0;
        tick();
        chk("t6_ack_off", 64'(bus3.m1_ack), 64'(0));
        chk("t6_gnt_off", 64'(bus3.m1_gnt), 64'(0));
        chk("t6_m0_gnt",  64'(bus3.m0_gnt), 64'(0));

        // single read by m0
        bus.s_rdata = 32'h00A5_5A00;
        bus.m0_req = 1'b1; bus.m0_wen = 1'b0; bus.m0_addr = 32'hFFFF_F070;
        tick();
        chk("t2_s_addr", 64'(bus.s_addr), 64'(32'hFFFF_F070));
        tick();
        chk("t2_ack",   64'(bus.m0_ack),   64'(1));
        chk("t2_rdata", 64'(bus.m0_rdata), 64'(32'h00A5_5A00));
        bus.m0_req = 1'b0;
        tick();

        // single write by m1
        acks = 0; wens = 0;
        bus.m1_req = 1'b1; bus.m1_wen = 1'b1; bus.m1_addr = 32'hFFFF_F060; bus.m1_wdata = 32'h0000_00FF;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.s_wen) begin
                wens++;
                chk("t3_wdata", 64'(bus.s_wdata), 64'(32'hFF));
            end
            if (bus.m1_ack) begin
                acks++;
                bus.m1_req = 1'b0;
            end
        end
        chk("t3_wen_pulses", 64'(wens), 64'(1));
        chk("t3_acks",       64'(acks), 64'(1));

        // contention with both requests held
        bus.m0_req = 1'b1; bus.m0_wen = 1'b0; bus.m0_addr = 32'hFFFF_F000;
        bus.m1_req = 1'b1; bus.m1_wen = 1'b0; bus.m1_addr = 32'hFFFF_F004;
        for (int i = 0; i < 40 && ack_cyc.size() < 4; i++) begin
            tick();
            if (bus.m0_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(0); end
            if (bus.m1_ack) begin ack_cyc.push_back(cyc); ack_who.push_back(1); end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        tick(); tick();
        chk("t4_ack_count", 64'(ack_cyc.size()), 64'(4));
        for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
            chk("t4_order", 64'(ack_who[i]), 64'(FIXED ? 0 : i % 2));
            if (i > 0) chk("t4_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(LAT + 2));
        end

        // m0 withdraws its write request during ACCESS
        acks = 0;
        bus.m0_req = 1'b1; bus.m0_wen = 1'b1; bus.m0_addr = 32'hFFFF_F050; bus.m0_wdata = 32'hAB;
        tick();
        chk("t5_wen", 64'(bus.s_wen), 64'(1));
        bus.m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.m0_ack) acks++;
        end
        chk("t5_acks",  64'(acks), 64'(1));
        chk("t5_gnt",   64'(bus.m0_gnt), 64'(0));
        chk("t5_wdata", 64'(bus.s_wdata), 64'(32'hAB));

        // random traffic, including withdrawals while granted
        for (int i = 0; i < 400; i++) begin
            bus.s_rdata = $urandom;
            if (exp_ack(1'b0)) bus.m0_req = 1'b0;
            else if (bus.m0_req && mk >= 1 && mk <= LAT && mown == 1'b0 && $urandom_range(0, 7) == 0)
                bus.m0_req = 1'b0;
            else if (!bus.m0_req && $urandom_range(0, 2) == 0) begin
                bus.m0_req = 1'b1; bus.m0_wen = 1'($urandom_range(0, 1));
                bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
            end
            if (exp_ack(1'b1)) bus.m1_req = 1'b0;
            else if (bus.m1_req && mk >= 1 && mk <= LAT && mown == 1'b1 && $urandom_range(0, 7) == 0)
                bus.m1_req = 1'b0;
            else if (!bus.m1_req && $urandom_range(0, 2) == 0) begin
                bus.m1_req = 1'b1; bus.m1_wen = 1'($urandom_range(0, 1));
                bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
            end
            tick();
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
